// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receive deserializer driven by a 16x-baud oversampling tick.
// The rx line is synchronized, the start bit is confirmed at its midpoint,
// then data (LSB first), an optional parity bit and the stop bit are sampled
// at bit centres. Each completed frame produces a one-cycle rx_done_tick with
// data, framing status and parity status.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   rx           in   serial line, asynchronous to clk, idle high
//   s_tick       in   16x-baud enable, one clk wide
//   dout         out  last received word, LSB = first bit on the wire
//   rx_done_tick out  one-cycle strobe; dout/frame_err/parity_err valid
//   frame_err    out  stop bit sampled low on the last frame
//   parity_err   out  parity mismatch on the last frame
//   busy         out  receiver is inside a frame
//
// state  | meaning
// IDLE   | waiting for the line to go low
// START  | counting to the centre of the start bit, rejecting glitches
// DATA   | sampling DBIT data bits at their centres
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then publishing the frame
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [4:0] MID_START = 5'd7;
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [3:0] N_LAST    = 4'(DBIT - 1);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  logic            r_rx_meta;
  logic            r_rx_s;
  logic [2:0]      r_state;
  logic [4:0]      r_s_cnt;
  logic [3:0]      r_n;
  logic [DBIT-1:0] r_shift;
  logic            r_par_bit;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            r_perr;

  logic            w_par_err;

  // Total ones across data and parity bit compared to the expected sense.
  assign w_par_err = PAR_EN & ((^r_shift ^ r_par_bit) != PAR_ODD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_s_cnt   <= 5'd0;
      r_n       <= 4'd0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A tick coinciding with detection is deliberately not counted.
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_s_cnt <= 5'd0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (r_s_cnt == MID_START) begin
              if (!r_rx_s) begin
                r_state <= ST_DATA;
                r_s_cnt <= 5'd0;
                r_n     <= 4'd0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_s_cnt == BIT_LAST) begin
              r_s_cnt <= 5'd0;
              r_shift <= {r_rx_s, r_shift[DBIT-1:1]};
              if (r_n == N_LAST) begin
                r_state <= PAR_EN ? ST_PARITY : ST_STOP;
              end else begin
                r_n <= r_n + 4'd1;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        ST_PARITY: begin
          if (s_tick) begin
            if (r_s_cnt == BIT_LAST) begin
              r_par_bit <= r_rx_s;
              r_s_cnt   <= 5'd0;
              r_state   <= ST_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (r_s_cnt == STOP_LAST) begin
              r_done  <= 1'b1;
              r_dout  <= r_shift;
              r_ferr  <= ~r_rx_s;
              r_perr  <= w_par_err;
              r_s_cnt <= 5'd0;
              r_state <= ST_IDLE;
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_s_cnt <= 5'd0;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign parity_err   = r_perr;
  // The FSM is already back in IDLE during the strobe; stretching busy over
  // that cycle keeps it continuous from start detect through the strobe.
  assign busy         = (r_state != ST_IDLE) | r_done;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Three receivers share clk, reset and s_tick: inst 0 default (8N1),
// inst 1 even parity, inst 2 odd parity. Each has its own rx line. Frames
// are built bit by bit on the wire; the expected word and status are
// derived from the transmitted bits and queued per instance, and a monitor
// per instance pops and compares on every rx_done_tick.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic [2:0] rx_l;
  logic [7:0] dout0, dout1, dout2;
  logic [2:0] done_l, fe_l, pe_l, busy_l;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  exp_t       q0[$], q1[$], q2[$];
  int         tq[$];
  logic [7:0] last_d0 = 8'h00;

  uart_rx u_d0 (
    .clk(clk), .reset(reset), .rx(rx_l[0]), .s_tick(s_tick),
    .dout(dout0), .rx_done_tick(done_l[0]), .frame_err(fe_l[0]),
    .parity_err(pe_l[0]), .busy(busy_l[0])
  );

  uart_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_d1 (
    .clk(clk), .reset(reset), .rx(rx_l[1]), .s_tick(s_tick),
    .dout(dout1), .rx_done_tick(done_l[1]), .frame_err(fe_l[1]),
    .parity_err(pe_l[1]), .busy(busy_l[1])
  );

  uart_rx #(.PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
    .clk(clk), .reset(reset), .rx(rx_l[2]), .s_tick(s_tick),
    .dout(dout2), .rx_done_tick(done_l[2]), .frame_err(fe_l[2]),
    .parity_err(pe_l[2]), .busy(busy_l[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 4 clk, changed on the falling edge.
  initial begin
    int tph;
    tph = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tph = (tph + 1) % 4;
      s_tick = (tph == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic on_strobe(input int k, input logic [7:0] d, input logic fe,
                           input logic pe, input logic bz);
    exp_t e;
    int   n;
    case (k)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL unexpected_strobe inst%0d: got dout=0x%0h, expected no strobe", k, d);
      return;
    end
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk($sformatf("dout_i%0d", k), 32'(d), 32'(e.d));
    chk($sformatf("frame_err_i%0d", k), 32'(fe), 32'(e.fe));
    chk($sformatf("parity_err_i%0d", k), 32'(pe), 32'(e.pe));
    chk($sformatf("busy_at_strobe_i%0d", k), 32'(bz), 32'd1);
    if (k == 0) tq.push_back(cyc);
  endtask

  always @(negedge clk) if (done_l[0]) on_strobe(0, dout0, fe_l[0], pe_l[0], busy_l[0]);
  always @(negedge clk) if (done_l[1]) on_strobe(1, dout1, fe_l[1], pe_l[1], busy_l[1]);
  always @(negedge clk) if (done_l[2]) on_strobe(2, dout2, fe_l[2], pe_l[2], busy_l[2]);

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: the word is exactly the data bits sent; the frame is
  // bad when the stop bit is 0; parity is judged by counting ones.
  task automatic send(input int k, input logic [7:0] d, input logic pbit,
                      input logic stop_ok);
    exp_t e;
    bit   has_par;
    int   odd;
    has_par = (k != 0);
    odd     = (k == 2) ? 1 : 0;
    e.d  = d;
    e.fe = !stop_ok;
    e.pe = has_par && ((($countones(d) + int'(pbit)) % 2) != odd);
    case (k)
      0:       begin q0.push_back(e); last_d0 = d; end
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    rx_l[k] = 1'b0;
    wait_clk(BIT_CLK);
    chk($sformatf("busy_in_frame_i%0d", k), 32'(busy_l[k]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rx_l[k] = d[i];
      wait_clk(BIT_CLK);
    end
    if (has_par) begin
      rx_l[k] = pbit;
      wait_clk(BIT_CLK);
    end
    if (stop_ok) begin
      rx_l[k] = 1'b1;
      wait_clk(BIT_CLK);
    end else begin
      // Short low stop so the following restart is rejected as a glitch.
      rx_l[k] = 1'b0;
      wait_clk(48);
      rx_l[k] = 1'b1;
      wait_clk(80);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dout"}, 32'(dout0), 32'd0);
    chk({tag, "_done"}, 32'(done_l[0]), 32'd0);
    chk({tag, "_frame_err"}, 32'(fe_l[0]), 32'd0);
    chk({tag, "_parity_err"}, 32'(pe_l[0]), 32'd0);
    chk({tag, "_busy"}, 32'(busy_l[0]), 32'd0);
  endtask

  initial begin
    logic [7:0] c3;
    reset = 1'b1;
    rx_l  = 3'b111;
    wait_clk(5);
    chk_zero_outputs("reset");
    reset = 1'b0;
    wait_clk(20);

    // Golden frame
    send(0, 8'hA5, 1'b0, 1'b1);
    wait_clk(40);

    // Glitch rejection
    rx_l[0] = 1'b0;
    wait_clk(8);
    chk("glitch_busy_high", 32'(busy_l[0]), 32'd1);
    wait_clk(8);
    rx_l[0] = 1'b1;
    wait_clk(64);
    chk("glitch_busy_low", 32'(busy_l[0]), 32'd0);
    chk("glitch_dout_held", 32'(dout0), 32'(last_d0));
    send(0, 8'h3C, 1'b0, 1'b1);
    wait_clk(20);

    // Framing error then recovery
    send(0, 8'h55, 1'b0, 1'b0);
    chk("ferr_held", 32'(fe_l[0]), 32'd1);
    send(0, 8'h0F, 1'b0, 1'b1);
    wait_clk(20);

    // Parity, even then odd
    send(1, 8'h07, 1'b1, 1'b1);
    send(1, 8'h07, 1'b0, 1'b1);
    send(2, 8'h07, 1'b1, 1'b1);
    send(2, 8'h07, 1'b0, 1'b1);
    wait_clk(20);

    // Back-to-back, no idle gap
    tq.delete();
    send(0, 8'h00, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1);
    send(0, 8'h81, 1'b0, 1'b1);
    chk("b2b_strobe_count", 32'(tq.size()), 32'd3);
    for (int i = 1; i < tq.size(); i++) begin
      int gap;
      gap = tq[i] - tq[i-1];
      checks++;
      if (gap < 636 || gap > 644) begin
        errors++;
        $display("FAIL b2b_gap%0d: got %0d clk, expected 640+-4 clk", i, gap);
      end
    end
    wait_clk(20);

    // Reset during data bit 3 of 0xC3
    c3 = 8'hC3;
    rx_l[0] = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      rx_l[0] = c3[i];
      wait_clk(BIT_CLK);
    end
    rx_l[0] = c3[3];
    wait_clk(32);
    reset = 1'b1;
    wait_clk(1);
    chk_zero_outputs("midreset");
    rx_l[0] = 1'b1;
    last_d0 = 8'h00;
    wait_clk(BIT_CLK);
    reset = 1'b0;
    wait_clk(BIT_CLK);
    chk("post_reset_busy", 32'(busy_l[0]), 32'd0);
    send(0, 8'h12, 1'b0, 1'b1);
    wait_clk(20);

    // Randomized frames
    for (int i = 0; i < 12; i++) begin
      send(0, 8'($urandom), 1'b0, ($urandom_range(0, 3) != 0));
      wait_clk($urandom_range(0, 40));
    end
    for (int i = 0; i < 6; i++) begin
      send(1, 8'($urandom), 1'($urandom), 1'b1);
      send(2, 8'($urandom), 1'($urandom), 1'b1);
      wait_clk($urandom_range(0, 40));
    end

    // Every queued frame must have been strobed by now.
    wait_clk(200);
    chk("pending_i0", 32'(q0.size()), 32'd0);
    chk("pending_i1", 32'(q1.size()), 32'd0);
    chk("pending_i2", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
